// File: rtl/addr_page_pkg.sv
// addr_page_pkg: shared constants and state type for the 0xF8-0xFF peripheral page
package addr_page_pkg;
  localparam logic [4:0] PAGE_BASE = 5'h1F;
  localparam int PAGE_IDX_W = 3;
  localparam int N_TGT = 8;
  localparam logic [7:0] IDLE_ADR_DEF = 8'h00;
  typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin pick, first set request after ptr (mod 8)
module rr_pick8
  import addr_page_pkg::*;
(
  input  logic [N_TGT-1:0]      req,
  input  logic [PAGE_IDX_W-1:0] ptr,
  output logic [PAGE_IDX_W-1:0] idx,
  output logic                  any
);
  always_comb begin
    idx = '0;
    any = |req;
    for (int k = N_TGT; k >= 1; k--)
      if (req[PAGE_IDX_W'(ptr + PAGE_IDX_W'(k))]) idx = ptr + PAGE_IDX_W'(k);
  end
endmodule

// File: rtl/addr_encoder8.sv
// addr_encoder8: round-robin bus initiator for the 8-way page; ADR_TIMEOUT_EN adds a no-ACK abort timeout
module addr_encoder8
  import addr_page_pkg::*;
#(
  parameter logic [4:0] BASE = PAGE_BASE,
  parameter logic [7:0] IDLE_ADR = IDLE_ADR_DEF
`ifdef ADR_TIMEOUT_EN
  , parameter int TO_W = 8
`endif
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_TGT-1:0] REQ,
  input  logic             ACK,
  output logic [7:0]       A,
  output logic             VALID,
  output logic [N_TGT-1:0] GNT,
  output logic             ERR
);
  state_t state, state_n;
  logic [PAGE_IDX_W-1:0] ptr, w, pick, sel;
  logic any, abort, done, v_n;
  logic [7:0] a_n;
  logic [N_TGT-1:0] g_n;
  rr_pick8 u_pick (.req(REQ), .ptr(ptr), .idx(pick), .any(any));
`ifdef ADR_TIMEOUT_EN
  logic [TO_W-1:0] cnt;
  // abort on the edge that would bring the count to all ones
  assign abort = state == BUSY && !ACK && cnt == {{(TO_W-1){1'b1}}, 1'b0};
  always_ff @(posedge CLK)
    cnt <= (!RST_N || state != BUSY) ? '0 : cnt + 1'b1;
`else
  assign abort = 1'b0;
`endif
  assign done = state == BUSY && (ACK || abort);
  always_comb
    state_n = state == IDLE ? (any ? BUSY : IDLE) : (done ? IDLE : BUSY);
  always_comb begin
    sel = state == IDLE ? pick : w;
    v_n = state_n == BUSY;
    a_n = v_n ? {BASE, sel} : IDLE_ADR;
    g_n = v_n ? N_TGT'(1) << sel : '0;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      ptr   <= '1;
      w     <= '0;
      A     <= IDLE_ADR;
      VALID <= 1'b0;
      GNT   <= '0;
      ERR   <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && any) w <= pick;
      if (done) ptr <= w;
      A     <= a_n;
      VALID <= v_n;
      GNT   <= g_n;
      ERR   <= abort;
    end
  end
endmodule

// File: tb/tb_addr_encoder8.sv
// tb_addr_encoder8: table-driven directed checks of addr_encoder8 (default build)
module tb_addr_encoder8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = '0;
  logic ack = 1'b0;
  logic [7:0] a, gnt;
  logic valid, err;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic [7:0] req;
    logic       ack;
    logic [7:0] a;
    logic       v;
    logic [7:0] g;
  } vec_t;
  vec_t tv[$];

  addr_encoder8 dut (.CLK(clk), .RST_N(rst_n), .REQ(req), .ACK(ack),
                     .A(a), .VALID(valid), .GNT(gnt), .ERR(err));

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] q, input logic k,
                     input logic [7:0] ea, input logic ev, input logic [7:0] eg);
    vec_t t;
    t.rst_n = r; t.req = q; t.ack = k; t.a = ea; t.v = ev; t.g = eg;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [7:0] q, input logic k);
    @(negedge clk);
    rst_n = r; req = q; ack = k;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset
    add(0, 8'h00, 0, 8'h00, 0, 8'h00);
    // single requester 0, ACK after 3 cycles, bubble, regrant
    add(1, 8'h01, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h00, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h00, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h01, 1, 8'h00, 0, 8'h00);
    add(1, 8'h01, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    // serve 5, then 0x21 grants 0 then 5
    add(1, 8'h20, 0, 8'hFD, 1, 8'h20);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    add(1, 8'h21, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h21, 1, 8'h00, 0, 8'h00);
    add(1, 8'h21, 0, 8'hFD, 1, 8'h20);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    // one-cycle REQ pulse on 3, long hold while REQ wanders
    add(1, 8'h08, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h00, 0, 8'hFB, 1, 8'h08);
    add(1, 8'hF7, 0, 8'hFB, 1, 8'h08);
    add(1, 8'hFF, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h01, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h80, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h10, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h00, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h55, 0, 8'hFB, 1, 8'h08);
    add(1, 8'hAA, 0, 8'hFB, 1, 8'h08);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    // reset with ACK while BUSY on 6, ACK in IDLE, pointer back at 7
    add(1, 8'h40, 0, 8'hFE, 1, 8'h40);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    add(1, 8'hFF, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);
    // 6 is next after 5 only if the pointer moved to 0: 0x41 picks 6
    add(1, 8'h41, 0, 8'hFE, 1, 8'h40);
    add(1, 8'h41, 1, 8'h00, 0, 8'h00);
    add(1, 8'h41, 0, 8'hF8, 1, 8'h01);
    add(1, 8'h00, 1, 8'h00, 0, 8'h00);

    foreach (tv[i]) begin
      step(tv[i].rst_n, tv[i].req, tv[i].ack);
      chk("A", i, a, tv[i].a);
      chk("VALID", i, 8'(valid), 8'(tv[i].v));
      chk("GNT", i, gnt, tv[i].g);
      chk("ERR", i, 8'(err), 8'h00);
    end

    // all requesting, ACK whenever VALID: F8..FF,F8 on alternate cycles
    begin
      logic ev;
      logic [2:0] nxt;
      step(0, 8'h00, 0);
      ev = 1'b0;
      nxt = 3'd0;
      for (int c = 0; c < 18; c++) begin
        step(1, 8'hFF, valid);
        if (!ev) ev = 1'b1;
        else begin
          ev = 1'b0;
          nxt = nxt + 3'd1;
        end
        chk("rr_A", c, a, ev ? {5'h1F, nxt} : 8'h00);
        chk("rr_VALID", c, 8'(valid), 8'(ev));
        chk("rr_GNT", c, gnt, ev ? 8'(1) << nxt : 8'h00);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
